// File: rtl/demux_pkg.sv
// Shared types and constants for the serial demux controller.
package demux_pkg;
  localparam int unsigned NUM_CH = 8;
  localparam int unsigned ADDR_W = 3;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-load, shift-left register with a bit counter.
// The MSB is emitted by the caller at load time, so the register keeps only the remaining bits.
module piso_shift_reg #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] load_data,
  output logic              bit_out,
  output logic              last
);
  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] sr;
  logic [CNT_W-1:0]  cnt;

  // cnt counts bits already presented; it saturates at DATA_W
  always_ff @(posedge clk) begin
    if (rst) begin
      sr  <= '0;
      cnt <= '0;
    end else if (load) begin
      sr  <= load_data << 1;
      cnt <= CNT_W'(1);
    end else if (shift && !last) begin
      sr  <= sr << 1;
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign bit_out = sr[DATA_W-1];
  assign last    = (cnt == CNT_W'(DATA_W));
endmodule

// File: rtl/demux_serial_ctrl.sv
// Serializes (addr, payload) frames MSB first onto data, with sel steering an external 1-to-8 demux.
module demux_serial_ctrl
  import demux_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned GAP_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  output logic [ADDR_W-1:0] sel,
  output logic              data,
  output logic              busy,
  output logic              done
);
  state_t     state;
  logic [3:0] gap_cnt;
  logic       accept;
  logic       shift_en;
  logic       bit_out;
  logic       last;

  assign in_ready = (state == IDLE) && !rst;
  assign accept   = in_valid && in_ready;
  assign shift_en = (state == SHIFT);

  piso_shift_reg #(.DATA_W(DATA_W)) u_piso (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .shift     (shift_en),
    .load_data (in_data),
    .bit_out   (bit_out),
    .last      (last)
  );

  // Frame FSM with registered outputs; gap_cnt saturates at GAP_CYC
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sel     <= '0;
      data    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      gap_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          data <= 1'b0;
          busy <= 1'b0;
          if (accept) begin
            state <= SHIFT;
            sel   <= in_addr;
            data  <= in_data[DATA_W-1];
            busy  <= 1'b1;
          end
        end
        SHIFT: begin
          if (last) begin
            state   <= GAP;
            data    <= 1'b0;
            done    <= 1'b1;
            gap_cnt <= 4'd1;
          end else begin
            data <= bit_out;
          end
        end
        GAP: begin
          data <= 1'b0;
          if (gap_cnt == 4'(GAP_CYC)) begin
            state   <= IDLE;
            busy    <= 1'b0;
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_demux_serial_ctrl.sv
// Directed bench for demux_serial_ctrl: default build plus a DATA_W=1, GAP_CYC=3 build.
module tb_demux_serial_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_addr;
  logic [7:0] in_data;
  logic [2:0] sel;
  logic       data;
  logic       busy;
  logic       done;

  logic       v1;
  logic       rdy1;
  logic [2:0] a1;
  logic [0:0] d1;
  logic [2:0] sel1;
  logic       data1;
  logic       busy1;
  logic       done1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  demux_serial_ctrl #(.DATA_W(8), .GAP_CYC(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data),
    .sel(sel), .data(data), .busy(busy), .done(done)
  );

  demux_serial_ctrl #(.DATA_W(1), .GAP_CYC(3)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1),
    .in_addr(a1), .in_data(d1),
    .sel(sel1), .data(data1), .busy(busy1), .done(done1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Checks one full MSB-first payload on the default instance, one bit per cycle
  task automatic expect_bits(input string tag, input logic [2:0] s, input logic [7:0] p);
    for (int i = 7; i >= 0; i--) begin
      cyc();
      chk({tag, "_data"}, 32'(data), 32'(p[i]));
      chk({tag, "_sel"},  32'(sel),  32'(s));
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_done"}, 32'(done), 32'd0);
    end
  endtask

  initial begin
    logic [7:0] pat;
    rst = 1'b1; in_valid = 1'b1; in_addr = 3'd4; in_data = 8'hFF;
    v1 = 1'b0; a1 = 3'd0; d1 = 1'b0;

    // Reset held for two edges with in_valid high
    cyc(); cyc();
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_sel",   32'(sel),      32'd0);
    chk("rst_data",  32'(data),     32'd0);
    chk("rst_busy",  32'(busy),     32'd0);
    chk("rst_done",  32'(done),     32'd0);
    rst = 1'b0; in_valid = 1'b0;
    #1 chk("rst_release_ready", 32'(in_ready), 32'd1);

    // Single frame addr 5, 8'hA5
    cyc();
    in_valid = 1'b1; in_addr = 3'd5; in_data = 8'hA5;
    cyc();
    chk("a5_first_data", 32'(data), 32'd1);
    chk("a5_first_sel",  32'(sel),  32'd5);
    in_valid = 1'b0; in_addr = 3'd0; in_data = 8'h00;
    pat = 8'hA5;
    for (int i = 6; i >= 0; i--) begin
      cyc();
      chk("a5_data", 32'(data), 32'(pat[i]));
      chk("a5_done", 32'(done), 32'd0);
    end
    cyc();
    chk("a5_done_pulse", 32'(done), 32'd1);
    chk("a5_gap_data",   32'(data), 32'd0);
    chk("a5_gap_busy",   32'(busy), 32'd1);
    chk("a5_gap_sel",    32'(sel),  32'd5);
    chk("a5_gap_ready",  32'(in_ready), 32'd0);
    cyc();
    chk("a5_idle_busy",  32'(busy), 32'd0);
    chk("a5_idle_done",  32'(done), 32'd0);
    chk("a5_idle_ready", 32'(in_ready), 32'd1);
    chk("a5_idle_sel",   32'(sel),  32'd5);

    // Back-to-back: A (2, FF) then B (7, 01) with in_valid held
    in_valid = 1'b1; in_addr = 3'd2; in_data = 8'hFF;
    cyc();
    chk("bb_a_first_sel", 32'(sel), 32'd2);
    chk("bb_a_first_data", 32'(data), 32'd1);
    in_addr = 3'd7; in_data = 8'h01;
    for (int i = 0; i < 7; i++) begin
      cyc();
      chk("bb_a_data", 32'(data), 32'd1);
      chk("bb_a_sel",  32'(sel),  32'd2);
    end
    cyc();
    chk("bb_a_done",  32'(done), 32'd1);
    chk("bb_a_gap_ready", 32'(in_ready), 32'd0);
    cyc();
    chk("bb_idle_ready", 32'(in_ready), 32'd1);
    chk("bb_idle_sel",   32'(sel),  32'd2);
    chk("bb_idle_busy",  32'(busy), 32'd0);
    cyc();
    chk("bb_b_first_sel",  32'(sel),  32'd7);
    chk("bb_b_first_data", 32'(data), 32'd0);
    chk("bb_b_first_busy", 32'(busy), 32'd1);
    in_valid = 1'b0;
    pat = 8'h01;
    for (int i = 6; i >= 0; i--) begin
      cyc();
      chk("bb_b_data", 32'(data), 32'(pat[i]));
      chk("bb_b_sel",  32'(sel),  32'd7);
    end
    cyc();
    chk("bb_b_done", 32'(done), 32'd1);
    cyc();
    chk("bb_b_idle", 32'(busy), 32'd0);

    // Mid-frame abort after the third bit of 8'hC3
    in_valid = 1'b1; in_addr = 3'd3; in_data = 8'hC3;
    cyc();
    in_valid = 1'b0;
    chk("ab_bit0", 32'(data), 32'd1);
    cyc();
    chk("ab_bit1", 32'(data), 32'd1);
    cyc();
    chk("ab_bit2", 32'(data), 32'd0);
    rst = 1'b1;
    cyc();
    chk("ab_rst_sel",   32'(sel),  32'd0);
    chk("ab_rst_data",  32'(data), 32'd0);
    chk("ab_rst_busy",  32'(busy), 32'd0);
    chk("ab_rst_done",  32'(done), 32'd0);
    chk("ab_rst_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1 chk("ab_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_addr = 3'd6; in_data = 8'h3C;
    cyc();
    chk("ab_new_no_done", 32'(done), 32'd0);
    chk("ab_new_first", 32'(data), 32'd0);
    chk("ab_new_sel",   32'(sel),  32'd6);
    in_valid = 1'b0;
    pat = 8'h3C;
    for (int i = 6; i >= 0; i--) begin
      cyc();
      chk("ab_new_data", 32'(data), 32'(pat[i]));
    end
    cyc();
    chk("ab_new_done", 32'(done), 32'd1);
    cyc();

    // Inputs toggled during SHIFT without a handshake must not disturb the frame
    in_valid = 1'b1; in_addr = 3'd1; in_data = 8'h96;
    pat = 8'h96;
    for (int i = 7; i >= 0; i--) begin
      cyc();
      chk("ig_data", 32'(data), 32'(pat[i]));
      chk("ig_sel",  32'(sel),  32'd1);
      in_addr  = ~in_addr;
      in_data  = ~in_data ^ 8'h5A;
      in_valid = (i != 0);
    end
    in_valid = 1'b0;
    cyc();
    chk("ig_done", 32'(done), 32'd1);
    chk("ig_gap_sel", 32'(sel), 32'd1);
    cyc();
    chk("ig_idle", 32'(busy), 32'd0);

    // DATA_W=1, GAP_CYC=3 build
    chk("w1_ready", 32'(rdy1), 32'd1);
    v1 = 1'b1; a1 = 3'd0; d1 = 1'b1;
    cyc();
    v1 = 1'b0; d1 = 1'b0;
    chk("w1_data", 32'(data1), 32'd1);
    chk("w1_busy0", 32'(busy1), 32'd1);
    chk("w1_done0", 32'(done1), 32'd0);
    chk("w1_sel",  32'(sel1), 32'd0);
    cyc();
    chk("w1_done", 32'(done1), 32'd1);
    chk("w1_gap_data", 32'(data1), 32'd0);
    chk("w1_busy1", 32'(busy1), 32'd1);
    cyc();
    chk("w1_busy2", 32'(busy1), 32'd1);
    chk("w1_done2", 32'(done1), 32'd0);
    cyc();
    chk("w1_busy3", 32'(busy1), 32'd1);
    chk("w1_ready3", 32'(rdy1), 32'd0);
    cyc();
    chk("w1_busy_end", 32'(busy1), 32'd0);
    chk("w1_ready_end", 32'(rdy1), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
